// File: rtl/bit_serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder.
//   state_e : controller states (IDLE, RUN, DONE), 2-bit encoding
//   clog2   : ceiling log2, used to size the slice counter
package bit_serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int clog2(input int value);
    int res;
    int v;
    res = 0;
    v   = value - 1;
    while (v > 0) begin
      res = res + 1;
      v   = v >> 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/bit_serial_adder_slice.sv
// Combinational DIGIT-bit ripple-carry adder slice.
//   x, y  : slice operands
//   ci    : carry into bit 0
//   s     : slice sum
//   co    : carry out of the slice MSB
//   c_msb : carry into the slice MSB (XOR with co gives signed overflow)
module adder_slice #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co,
  output logic             c_msb
);

  logic [DIGIT:0] c;

  // NOTE: every variable written in always_comb gets a default first, so no
  // path through the block leaves it unassigned and a latch is never inferred.
  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int i = 0; i < DIGIT; i++) begin
      s[i]     = x[i] ^ y[i] ^ c[i];
      c[i + 1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end
  end

  assign co    = c[DIGIT];
  assign c_msb = c[DIGIT - 1];

endmodule

// File: rtl/bit_serial_adder.sv
// Parametrised bit-serial adder: WIDTH-bit operands are shifted LSB-first and
// added DIGIT bits per cycle with a registered carry. Result appears N+1 cycles
// after an accepted start (N = WIDTH/DIGIT) with a one-cycle done pulse.
// Optional feature macro: SERIAL_ADDER_SUB_EN adds a subtract mode (sub input)
// and a signed-overflow flag (ovf output).
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   start      : request, sampled only while ready
//   a, b, cin  : operands and carry-in, captured on an accepted start
//   ready      : idle and able to accept
//   busy       : serial addition in progress
//   done       : one-cycle pulse, sum/cout valid
//   sum, cout  : result and carry-out, held until the next result
//   sub, ovf   : (SERIAL_ADDER_SUB_EN only) subtract request, signed overflow
module bit_serial_adder
  import bit_serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_SUB_EN
  ,
  input  logic             sub,
  output logic             ovf
`endif
);

  if (DIGIT < 1 || WIDTH < 2 || (WIDTH % DIGIT) != 0) begin : g_bad_params
    $error("bit_serial_adder: WIDTH must be >= 2 and DIGIT must divide WIDTH");
  end

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (clog2(N) > 0) ? clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [WIDTH-1:0]   sum_sh_q, sum_sh_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
`ifdef SERIAL_ADDER_SUB_EN
  logic               ovf_q, ovf_d;
`endif

  logic [DIGIT-1:0]   slice_s;
  logic               slice_co;
  logic               slice_c_msb;
  logic [WIDTH-1:0]   sum_sh_next;

  adder_slice #(.DIGIT(DIGIT)) u_slice (
    .x     (a_sh_q[DIGIT-1:0]),
    .y     (b_sh_q[DIGIT-1:0]),
    .ci    (carry_q),
    .s     (slice_s),
    .co    (slice_co),
    .c_msb (slice_c_msb)
  );

  // The new slice enters at the MSB end, so after N shifts slice 0 sits at the LSB.
  if (DIGIT < WIDTH) begin : g_shift
    assign sum_sh_next = {slice_s, sum_sh_q[WIDTH-1:DIGIT]};
  end else begin : g_single
    assign sum_sh_next = slice_s;
  end

`ifndef SERIAL_ADDER_SUB_EN
  // Carry into the MSB only matters for the overflow flag.
  logic unused_c_msb;
  assign unused_c_msb = slice_c_msb;
`endif

  // State register and datapath registers.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // its _d value from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      carry_q  <= 1'b0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      carry_q  <= carry_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
`ifdef SERIAL_ADDER_SUB_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (count_q == LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: load on accept, shift/add while running, and
  // capture the finished result on the last RUN cycle.
  always_comb begin
    count_d  = count_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    carry_d  = carry_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
`ifdef SERIAL_ADDER_SUB_EN
    ovf_d    = ovf_q;
`endif
    if (state_q == IDLE && start) begin
      count_d = '0;
      a_sh_d  = a;
`ifdef SERIAL_ADDER_SUB_EN
      // Two's-complement subtract: a + ~b + 1.
      b_sh_d  = sub ? ~b : b;
      carry_d = sub ? 1'b1 : cin;
`else
      b_sh_d  = b;
      carry_d = cin;
`endif
    end else if (state_q == RUN) begin
      count_d  = count_q + CNT_W'(1);
      a_sh_d   = a_sh_q >> DIGIT;
      b_sh_d   = b_sh_q >> DIGIT;
      sum_sh_d = sum_sh_next;
      carry_d  = slice_co;
      if (count_q == LAST) begin
        sum_d  = sum_sh_next;
        cout_d = slice_co;
`ifdef SERIAL_ADDER_SUB_EN
        ovf_d  = slice_c_msb ^ slice_co;
`endif
      end
    end
  end

  // Outputs.
  always_comb begin
    ready = (state_q == IDLE);
    busy  = (state_q == RUN);
    done  = (state_q == DONE);
  end

  assign sum  = sum_q;
  assign cout = cout_q;
`ifdef SERIAL_ADDER_SUB_EN
  assign ovf  = ovf_q;
`endif

endmodule
